// File: rtl/cprv_pkg.sv
// Shared definitions for the writeback path of the integer core.
// Holds the default widths and the producer index encoding.
// The writeback controller and the arbiter both use these definitions.
package cprv_pkg;

    localparam int DATA_WIDTH    = 64;
    localparam int REGADDR_WIDTH = 5;
    localparam int NUM_SRC       = 3;

    // Producer slot numbers on the writeback port.
    typedef enum logic [1:0] {
        WB_ALU    = 2'd0,
        WB_LSU    = 2'd1,
        WB_MULDIV = 2'd2
    } wb_src_e;

endpackage

// File: rtl/cprv_rr_arbiter.sv
// Round-robin arbiter with a registered priority pointer.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   req        : one request bit per source
//   gnt        : one-hot grant, combinational from req and the pointer
//   gnt_any    : high when some source is granted this cycle
// After a source is granted, the pointer moves to the next source.
// With no grant, the pointer keeps its value.
module cprv_rr_arbiter
    import cprv_pkg::*;
#(
    parameter int N = NUM_SRC
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt,
    output logic         gnt_any
);

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] gnt_idx;

    // Scan the sources from the pointer upward and wrap at N.
    // The first requester found gets the grant.
    always_comb begin
        int idx;
        idx     = 0;
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!gnt_any && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_idx  = IDX_W'(idx);
                gnt_any  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (gnt_any) begin
            ptr <= (gnt_idx == IDX_W'(N - 1)) ? '0 : gnt_idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/cprv_wb_ctrl.sv
// Writeback controller and register scoreboard.
// It shares one regfile write port among the producers in round-robin order.
// It keeps one pending-write bit for each architectural register.
// It stalls issue on RAW and WAW hazards against those pending writes.
// Ports:
//   clk, rst_n      : clock and asynchronous active-low reset
//   flush           : clears all pending-write bits at the next edge
//   src_valid/ready : per-producer writeback handshake
//   src_rd_addr/data: packed per-producer destination and data
//   issue_*         : decode-side instruction and its hazard stall
//   rf_rd_en/addr/data : regfile write port
module cprv_wb_ctrl
    import cprv_pkg::*;
#(
    parameter int DATA_WIDTH    = cprv_pkg::DATA_WIDTH,
    parameter int REGADDR_WIDTH = cprv_pkg::REGADDR_WIDTH,
    parameter int NUM_SRC       = cprv_pkg::NUM_SRC
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             flush,
    input  logic [NUM_SRC-1:0]               src_valid,
    output logic [NUM_SRC-1:0]               src_ready,
    input  logic [NUM_SRC*REGADDR_WIDTH-1:0] src_rd_addr,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]    src_rd_data,
    input  logic                             issue_valid,
    input  logic                             issue_uses_rd,
    input  logic [REGADDR_WIDTH-1:0]         issue_rd_addr,
    input  logic [REGADDR_WIDTH-1:0]         issue_rs1_addr,
    input  logic [REGADDR_WIDTH-1:0]         issue_rs2_addr,
    output logic                             issue_stall,
    output logic                             rf_rd_en,
    output logic [REGADDR_WIDTH-1:0]         rf_rd_addr,
    output logic [DATA_WIDTH-1:0]            rf_rd_data
);

    localparam int NUM_REGS = 2 ** REGADDR_WIDTH;

    logic [NUM_SRC-1:0]       req;
    logic [NUM_SRC-1:0]       gnt;
    logic                     gnt_any;
    logic [REGADDR_WIDTH-1:0] wb_addr;
    logic [DATA_WIDTH-1:0]    wb_data;
    logic [NUM_REGS-1:0]      busy;
    logic [NUM_REGS-1:0]      clr_vec;
    logic [NUM_REGS-1:0]      set_vec;
    logic [NUM_REGS-1:0]      pend;
    logic                     issue_fire;

    // Mask the requests during reset.
    // This forces every grant-derived output to 0 without waiting for a clock.
    assign req = src_valid & {NUM_SRC{rst_n}};

    cprv_rr_arbiter #(.N(NUM_SRC)) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .gnt     (gnt),
        .gnt_any (gnt_any)
    );

    // Drive the write port with zeros when idle.
    // The regfile forwards rd_data on an address match even when rd_en is low.
    // An idle cycle must therefore only ever forward 0 onto x0.
    always_comb begin
        wb_addr = '0;
        wb_data = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (gnt[i]) begin
                wb_addr = src_rd_addr[i*REGADDR_WIDTH +: REGADDR_WIDTH];
                wb_data = src_rd_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign src_ready  = gnt;
    assign rf_rd_addr = wb_addr;
    assign rf_rd_data = wb_data;
    assign rf_rd_en   = gnt_any && (wb_addr != '0);

    always_comb begin
        clr_vec = '0;
        if (rf_rd_en) begin
            clr_vec[wb_addr] = 1'b1;
        end
    end

    // A register that retires this cycle is no longer a hazard.
    // The regfile forwards the value being written.
    // Bit 0 is masked so that x0 can never stall.
    assign pend = busy & ~clr_vec & ~NUM_REGS'(1);

    assign issue_stall = rst_n && issue_valid &&
                         (pend[issue_rs1_addr] || pend[issue_rs2_addr] ||
                          (issue_uses_rd && pend[issue_rd_addr]));

    assign issue_fire = issue_valid && !issue_stall && issue_uses_rd &&
                        (issue_rd_addr != '0);

    always_comb begin
        set_vec = '0;
        if (issue_fire) begin
            set_vec[issue_rd_addr] = 1'b1;
        end
    end

    // The set term is ORed in after the clear is applied.
    // A new writer therefore wins over a retiring one on the same register.
    // Flush takes priority over both the set and the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else if (flush) begin
            busy <= '0;
        end else begin
            busy <= (busy & ~clr_vec) | set_vec;
        end
    end

endmodule

// File: tb/tb_cprv_wb_ctrl.sv
// Directed, scoreboard-based bench for cprv_wb_ctrl.
// Each step computes the expected write-port and stall values from a small
// behavioural model and pushes them onto a queue.
// Each entry is popped and compared at the falling edge that follows.
// The model state (priority pointer, busy bits) then advances at the rising edge.
module tb_cprv_wb_ctrl;
    import cprv_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic [2:0]  src_valid;
    logic [2:0]  src_ready;
    logic [14:0] src_rd_addr;
    logic [191:0] src_rd_data;
    logic        issue_valid;
    logic        issue_uses_rd;
    logic [4:0]  issue_rd_addr;
    logic [4:0]  issue_rs1_addr;
    logic [4:0]  issue_rs2_addr;
    logic        issue_stall;
    logic        rf_rd_en;
    logic [4:0]  rf_rd_addr;
    logic [63:0] rf_rd_data;

    logic [4:0]  s_addr [3];
    logic [63:0] s_data [3];

    assign src_rd_addr = {s_addr[2], s_addr[1], s_addr[0]};
    assign src_rd_data = {s_data[2], s_data[1], s_data[0]};

    cprv_wb_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .src_valid      (src_valid),
        .src_ready      (src_ready),
        .src_rd_addr    (src_rd_addr),
        .src_rd_data    (src_rd_data),
        .issue_valid    (issue_valid),
        .issue_uses_rd  (issue_uses_rd),
        .issue_rd_addr  (issue_rd_addr),
        .issue_rs1_addr (issue_rs1_addr),
        .issue_rs2_addr (issue_rs2_addr),
        .issue_stall    (issue_stall),
        .rf_rd_en       (rf_rd_en),
        .rf_rd_addr     (rf_rd_addr),
        .rf_rd_data     (rf_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  ready;
        logic        en;
        logic [4:0]  addr;
        logic [63:0] data;
        logic        stall;
        int          g;
        logic        fire;
        logic        flush;
        logic        in_reset;
    } exp_t;

    exp_t        sb [$];
    int          rr_m;
    logic [31:0] busy_m;
    int          n_checks;
    int          n_fail;
    logic        chk_addr_en;
    logic [4:0]  chk_addr_exp;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compute the expected outputs for the inputs currently being driven.
    task automatic applyStimulus();
        exp_t e;
        logic hit_rs1, hit_rs2, hit_rd;
        e.ready = '0; e.en = 1'b0; e.addr = '0; e.data = '0; e.stall = 1'b0;
        e.g = -1; e.fire = 1'b0; e.flush = flush; e.in_reset = !rst_n;
        if (!rst_n) begin
            rr_m   = 0;
            busy_m = '0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                int i;
                i = (rr_m + k) % 3;
                if (e.g < 0 && src_valid[i]) e.g = i;
            end
            if (e.g >= 0) begin
                e.ready[e.g] = 1'b1;
                e.addr = s_addr[e.g];
                e.data = s_data[e.g];
                e.en   = (s_addr[e.g] != 0);
            end
            hit_rs1 = (issue_rs1_addr != 0) && busy_m[issue_rs1_addr] &&
                      !(e.g >= 0 && e.addr == issue_rs1_addr);
            hit_rs2 = (issue_rs2_addr != 0) && busy_m[issue_rs2_addr] &&
                      !(e.g >= 0 && e.addr == issue_rs2_addr);
            hit_rd  = (issue_rd_addr != 0) && busy_m[issue_rd_addr] &&
                      !(e.g >= 0 && e.addr == issue_rd_addr);
            e.stall = issue_valid && (hit_rs1 || hit_rs2 || (issue_uses_rd && hit_rd));
            e.fire  = issue_valid && !e.stall && issue_uses_rd && (issue_rd_addr != 0);
        end
        sb.push_back(e);
    endtask

    // Compare at the falling edge, then advance the model across the rising edge.
    task automatic checkOutput(input string tag);
        exp_t e;
        @(negedge clk);
        e = sb.pop_front();
        check({tag, ".busy"},  dut.busy, busy_m);
        check({tag, ".ready"}, src_ready, e.ready);
        check({tag, ".en"},    rf_rd_en, e.en);
        check({tag, ".addr"},  rf_rd_addr, e.addr);
        check({tag, ".data"},  rf_rd_data, e.data);
        check({tag, ".stall"}, issue_stall, e.stall);
        check({tag, ".onehot"}, ($countones(src_ready) <= 1), 1'b1);
        if (chk_addr_en) check({tag, ".rraddr"}, rf_rd_addr, chk_addr_exp);
        @(posedge clk);
        if (!e.in_reset) begin
            if (e.g >= 0) begin
                rr_m = (e.g + 1) % 3;
                if (e.addr != 0) busy_m[e.addr] = 1'b0;
            end
            if (e.fire) busy_m[issue_rd_addr] = 1'b1;
            if (e.flush) busy_m = '0;
        end
        #1;
    endtask

    task automatic step(input string tag);
        applyStimulus();
        checkOutput(tag);
    endtask

    task automatic setIdle();
        flush = 1'b0; src_valid = '0;
        issue_valid = 1'b0; issue_uses_rd = 1'b0;
        issue_rd_addr = '0; issue_rs1_addr = '0; issue_rs2_addr = '0;
        for (int i = 0; i < 3; i++) begin s_addr[i] = '0; s_data[i] = '0; end
    endtask

    task automatic setIssue(input logic uses, input logic [4:0] rd,
                            input logic [4:0] rs1, input logic [4:0] rs2);
        issue_valid = 1'b1; issue_uses_rd = uses;
        issue_rd_addr = rd; issue_rs1_addr = rs1; issue_rs2_addr = rs2;
    endtask

    initial begin
        logic [4:0] rr_addrs [6];
        rr_addrs = '{5'd5, 5'd6, 5'd7, 5'd5, 5'd6, 5'd7};
        n_checks = 0; n_fail = 0; rr_m = 0; busy_m = '0;
        chk_addr_en = 1'b0; chk_addr_exp = '0;
        rst_n = 1'b0;
        setIdle();
        s_addr[WB_ALU] = 5'd5; s_addr[WB_LSU] = 5'd6; s_addr[WB_MULDIV] = 5'd7;
        s_data[WB_ALU] = 64'hA; s_data[WB_LSU] = 64'hB; s_data[WB_MULDIV] = 64'hC;
        src_valid = 3'b111;
        #1;
        step("reset_hold");

        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk_addr_en = 1'b1; chk_addr_exp = rr_addrs[i];
            step("rr");
        end
        chk_addr_en = 1'b0;

        // Assert reset while all producers are still requesting.
        step("pre_reset");
        rst_n = 1'b0;
        step("reset_mid");
        rst_n = 1'b1;
        chk_addr_en = 1'b1; chk_addr_exp = 5'd5;
        step("first_after_reset");
        chk_addr_en = 1'b0;

        setIdle();
        step("idle");

        // RAW hazard: the issue is held until the LSU retires x3.
        setIssue(1'b1, 5'd3, 5'd0, 5'd0);
        step("raw_set");
        setIssue(1'b0, 5'd0, 5'd3, 5'd0);
        step("raw_stall1");
        step("raw_stall2");
        src_valid[WB_LSU] = 1'b1; s_addr[WB_LSU] = 5'd3; s_data[WB_LSU] = 64'h33;
        step("raw_release");
        setIdle();
        setIssue(1'b0, 5'd0, 5'd0, 5'd3);
        step("raw_clear");

        // WAW while retiring: the new writer keeps busy[8] set.
        setIdle();
        setIssue(1'b1, 5'd8, 5'd0, 5'd0);
        step("waw_set");
        src_valid[WB_ALU] = 1'b1; s_addr[WB_ALU] = 5'd8; s_data[WB_ALU] = 64'h88;
        step("waw_setwins");
        setIdle();
        setIssue(1'b1, 5'd8, 5'd0, 5'd0);
        step("waw_stall");
        setIdle();
        src_valid[WB_ALU] = 1'b1; s_addr[WB_ALU] = 5'd8; s_data[WB_ALU] = 64'h89;
        step("waw_retire");

        // x0 is never tracked; a writeback to it is consumed without a write.
        setIdle();
        setIssue(1'b1, 5'd0, 5'd0, 5'd0);
        step("x0_issue");
        setIdle();
        src_valid[WB_MULDIV] = 1'b1; s_addr[WB_MULDIV] = 5'd0; s_data[WB_MULDIV] = 64'hFFFF;
        step("x0_wb");
        setIdle();
        s_data[WB_LSU] = 64'h1234;
        step("idle_zero");

        // Flush clears busy and overrides a same-cycle issue.
        setIdle();
        setIssue(1'b1, 5'd4, 5'd0, 5'd0);
        step("flush_set4");
        setIssue(1'b1, 5'd9, 5'd4, 5'd0);
        step("flush_stall_rs1");
        setIssue(1'b1, 5'd9, 5'd0, 5'd0);
        step("flush_set9");
        setIssue(1'b1, 5'd12, 5'd0, 5'd0);
        flush = 1'b1;
        step("flush");
        setIdle();
        src_valid[WB_ALU] = 1'b1; s_addr[WB_ALU] = 5'd4; s_data[WB_ALU] = 64'h44;
        setIssue(1'b0, 5'd0, 5'd9, 5'd12);
        step("post_flush_wb");
        setIdle();
        step("post_flush_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cprv_wb_ctrl.md
Name: cprv_wb_ctrl

Overview:
- Writeback controller and scoreboard for the single-write-port integer register file.
- Arbitrates the one write port round-robin between NUM_SRC writeback producers (ALU, LSU, MULDIV) using valid/ready handshakes.
- Tracks a pending-write busy bit per architectural register and stalls issue on RAW/WAW hazards.
- Sits between the execute units and the register file. It drives the regfile write port (rd_addr, rd_en, rd_data) directly.

Parameters:
- DATA_WIDTH, 64: register data width.
- REGADDR_WIDTH, 5: register address width; 2**REGADDR_WIDTH registers.
- NUM_SRC, 3: number of writeback producers (index 0 = ALU, 1 = LSU, 2 = MULDIV).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  pipeline flush; clears the scoreboard.
- src_valid  in  NUM_SRC  per-producer writeback request.
- src_ready  out  NUM_SRC  per-producer grant; a transfer completes when valid and ready are both high.
- src_rd_addr  in  NUM_SRC*REGADDR_WIDTH  packed destination addresses; src i at [i*REGADDR_WIDTH +: REGADDR_WIDTH].
- src_rd_data  in  NUM_SRC*DATA_WIDTH  packed writeback data, same packing.
- issue_valid  in  1  decode has an instruction to issue.
- issue_uses_rd  in  1  the instruction writes rd.
- issue_rd_addr  in  REGADDR_WIDTH  destination of the issuing instruction.
- issue_rs1_addr  in  REGADDR_WIDTH  source 1.
- issue_rs2_addr  in  REGADDR_WIDTH  source 2.
- issue_stall  out  1  hold issue this cycle.
- rf_rd_en  out  1  regfile write enable.
- rf_rd_addr  out  REGADDR_WIDTH  regfile write address.
- rf_rd_data  out  DATA_WIDTH  regfile write data.

Behaviour:
- State:
  - rr_ptr: index of the highest-priority source.
  - busy[2**REGADDR_WIDTH-1:0]: pending-write bits.
- Reset (rst_n low, async): rr_ptr=0, busy=0. While in reset all outputs are combinationally 0: src_ready=0, rf_rd_en=0, rf_rd_addr=0, rf_rd_data=0, issue_stall=0.
- Arbitration (combinational, zero latency):
  - Grant the first valid source searching rr_ptr, rr_ptr+1, ... modulo NUM_SRC.
  - At most one src_ready is high per cycle, and only on a valid source.
  - On a grant to source g, rr_ptr <= (g+1) mod NUM_SRC at the next edge. With no grant, rr_ptr holds.
- Write port:
  - On grant: rf_rd_addr = src addr, rf_rd_data = src data, rf_rd_en = (addr != 0).
  - A grant to x0 is consumed (ready high) without a write.
  - With no grant, rf_rd_addr=0, rf_rd_data=0, rf_rd_en=0. This is mandatory: the regfile forwards rd_data to any read port whose address matches rd_addr regardless of rd_en, so idle outputs must forward only 0 onto x0 reads.
- Writeback hit: wb_hit(a) = grant && rf_rd_addr==a && a!=0.
- Stall: issue_stall = issue_valid && (H(rs1) || H(rs2) || (issue_uses_rd && H(rd))), where H(a) = a!=0 && busy[a] && !wb_hit(a).
  - A same-cycle writeback to a source register does not stall; the regfile forwards the value.
  - WAW on a busy rd stalls unless that rd is retiring this cycle.
- Issue fire: issue_valid && !issue_stall && issue_uses_rd && issue_rd_addr!=0 sets busy[issue_rd_addr].
- Busy clear: a granted writeback with addr!=0 clears busy[addr].
- Simultaneous set and clear of the same register: set wins.
- busy[0] is never set.
- flush: busy <= 0 at the next edge; flush overrides a same-cycle issue set; rr_ptr is unaffected.
  - Writebacks arriving after a flush are still granted and written. Squashing them is the producer's responsibility.
- A writeback to a non-busy register (post-flush) is granted normally. The clear is a no-op.
- Producers must hold valid, addr and data stable until ready.

Decomposition:
- Shared package cprv_pkg: REGADDR_WIDTH, DATA_WIDTH, NUM_SRC, and an enum wb_src_e {WB_ALU, WB_LSU, WB_MULDIV} for producer indices.
- One natural sub-module: cprv_rr_arbiter, a parameterised NUM_SRC round-robin arbiter with req/gnt one-hot and an internal pointer. The scoreboard and stall logic stay in cprv_wb_ctrl.

Test Plan:
- Reset: assert rst_n=0 mid-transfer with src_valid=3'b111 -> src_ready=0, rf_rd_en=0, rf_rd_addr=0. After release, the first grant goes to src 0 and busy is all zero.
- Round-robin: all three valid for 6 cycles (addrs 5/6/7, data 0xA/0xB/0xC) -> grants 0,1,2,0,1,2; rf_rd_addr 5,6,7,5,6,7 with matching data; never two readys.
- RAW stall: issue rd=3 fires. Next cycle issue rs1=3 -> issue_stall=1 until an LSU writeback to x3 is granted. In that grant cycle issue_stall=0 and rf_rd_addr=3.
- WAW plus set-wins: busy[8]=1; the ALU writes x8 while issue rd=8 fires the same cycle -> no stall, and busy[8]=1 afterward.
- x0: issue rd=0 leaves busy unchanged. A writeback to x0 with data 0xFFFF gives src_ready=1, rf_rd_en=0, rf_rd_data=0xFFFF. When idle, rf_rd_data=0.
- Flush: busy[4] and busy[9] set; flush=1 together with issue rd=12 -> busy all zero next cycle. A later writeback to x4 is granted with rf_rd_en=1 and busy stays 0.
